// File: rtl/cmp2_bist.sv
// cmp2_bist: self-checking sweep of a 2-bit magnitude comparator.
// Ports: clk, rst_n, start in; a1..b0 operand drive out; a_gt_b,
// b_gt_a, a_eq_b results in; busy, done, pass, err_count,
// fail_valid, fail_vec status out. SETTLE_CYCLES = wait per vector.
module cmp2_bist #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a1,
  output logic       a0,
  output logic       b1,
  output logic       b0,
  input  logic       a_gt_b,
  input  logic       b_gt_a,
  input  logic       a_eq_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LOAD   = SETTLE - 4'd1;

  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] err, err_n;
  logic       fval, fval_n;
  logic [3:0] fvec, fvec_n;

  logic [1:0] op_a, op_b;
  logic [2:0] expv, got;
  logic       miss;

  assign op_a = idx[3:2];
  assign op_b = idx[1:0];
  assign expv = {op_a > op_b, op_b > op_a, op_a == op_b};
  assign got  = {a_gt_b, b_gt_a, a_eq_b};
  // Any bit difference fails, so multi-hot and all-zero are caught.
  assign miss = (got != expv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      err   <= '0;
      fval  <= 1'b0;
      fvec  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      err   <= err_n;
      fval  <= fval_n;
      fvec  <= fvec_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    err_n   = err;
    fval_n  = fval;
    fvec_n  = fvec;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = DRIVE;
          idx_n   = '0;
          err_n   = '0;
          fval_n  = 1'b0;
          fvec_n  = '0;
        end
      end
      DRIVE: begin
        if (SETTLE != 4'd0) begin
          state_n = WAIT;
          cnt_n   = LOAD;
        end else begin
          state_n = CHECK;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_n = CHECK;
        else cnt_n = cnt - 4'd1;
      end
      CHECK: begin
        if (miss) begin
          err_n = err + 5'd1;
          if (!fval) begin
            fval_n = 1'b1;
            fvec_n = idx;
          end
        end
        // idx stays at 15 once the sweep ends.
        if (idx == 4'd15) begin
          state_n = DONE;
        end else begin
          idx_n   = idx + 4'd1;
          state_n = DRIVE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign {a1, a0, b1, b0} = idx;

  assign busy       = (state == DRIVE) ||
                      (state == WAIT) ||
                      (state == CHECK);
  assign done       = (state == DONE);
  assign pass       = done && (err == 5'd0);
  assign err_count  = err;
  assign fail_valid = fval;
  assign fail_vec   = fvec;

endmodule

// File: tb/tb_cmp2_bist.sv
// tb_cmp2_bist: drives three BIST instances (settle 1, 0, 3) against
// a fault-injectable comparator model and checks sweep results.
module tb_cmp2_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start = '0;

  logic [2:0] busy, done, pass, fval;
  logic [2:0][4:0] errc;
  logic [2:0][3:0] fvec, opv;
  logic [2:0][2:0] res;

  // Per-vector XOR corruption of the comparator result.
  logic [2:0] mask [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [2:0] golden(logic [3:0] v);
    int a, b;
    a = int'(v[3:2]);
    b = int'(v[1:0]);
    return {a > b, b > a, a == b};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    assign res[g] = golden(opv[g]) ^ mask[opv[g]];
    cmp2_bist #(.SETTLE_CYCLES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .a1        (opv[g][3]),
      .a0        (opv[g][2]),
      .b1        (opv[g][1]),
      .b0        (opv[g][0]),
      .a_gt_b    (res[g][2]),
      .b_gt_a    (res[g][1]),
      .a_eq_b    (res[g][0]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .err_count (errc[g]),
      .fail_valid(fval[g]),
      .fail_vec  (fvec[g])
    );
  end

  task automatic chk(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int settle_of(int g);
    return (g == 0) ? 1 : (g == 1) ? 0 : 3;
  endfunction

  task automatic clear_mask();
    for (int i = 0; i < 16; i++) mask[i] = 3'b000;
  endtask

  task automatic chk_reset(int g);
    chk($sformatf("rst_op%0d", g), int'(opv[g]), 0);
    chk($sformatf("rst_busy%0d", g), int'(busy[g]), 0);
    chk($sformatf("rst_done%0d", g), int'(done[g]), 0);
    chk($sformatf("rst_pass%0d", g), int'(pass[g]), 0);
    chk($sformatf("rst_err%0d", g), int'(errc[g]), 0);
    chk($sformatf("rst_fval%0d", g), int'(fval[g]), 0);
    chk($sformatf("rst_fvec%0d", g), int'(fvec[g]), 0);
  endtask

  // Called at the negedge right after the start edge E0.
  task automatic body(int g, bit repulse);
    int s, per, n;
    int e_err, e_fv;
    bit e_val;
    s = settle_of(g);
    per = 2 + s;
    n = 16 * per;
    chk($sformatf("clr_err%0d", g), int'(errc[g]), 0);
    chk($sformatf("clr_fval%0d", g), int'(fval[g]), 0);
    for (int j = 1; j <= n; j++) begin
      chk($sformatf("busy%0d_c%0d", g, j), int'(busy[g]), 1);
      chk($sformatf("done%0d_c%0d", g, j), int'(done[g]), 0);
      chk($sformatf("op%0d_c%0d", g, j), int'(opv[g]), (j - 1) / per);
      if (repulse && j == 10) start[g] = 1'b1;
      if (repulse && j == 11) start[g] = 1'b0;
      @(negedge clk);
    end
    e_err = 0;
    e_fv = 0;
    e_val = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i] != 3'b000) begin
        if (!e_val) e_fv = i;
        e_val = 1'b1;
        e_err++;
      end
    end
    chk($sformatf("end_busy%0d", g), int'(busy[g]), 0);
    chk($sformatf("end_done%0d", g), int'(done[g]), 1);
    chk($sformatf("end_err%0d", g), int'(errc[g]), e_err);
    chk($sformatf("end_fval%0d", g), int'(fval[g]), int'(e_val));
    chk($sformatf("end_fvec%0d", g), int'(fvec[g]), e_fv);
    chk($sformatf("end_pass%0d", g), int'(pass[g]), int'(e_err == 0));
    chk($sformatf("end_op%0d", g), int'(opv[g]), 15);
  endtask

  task automatic sweep(int g, bit repulse);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    body(g, repulse);
  endtask

  initial begin
    clear_mask();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) chk_reset(g);
    rst_n = 1'b1;
    @(negedge clk);

    // Golden comparator, every settle setting.
    for (int g = 0; g < 3; g++) sweep(g, 1'b0);

    // a_eq_b stuck at 0.
    for (int i = 0; i < 16; i++)
      mask[i] = golden(4'(i)) & 3'b001;
    sweep(0, 1'b0);

    // b_gt_a inverted only for A=2, B=1.
    clear_mask();
    mask[9] = 3'b010;
    sweep(2, 1'b0);

    // Multi-hot and all-zero outputs.
    clear_mask();
    mask[5] = 3'b001;
    mask[12] = 3'b011;
    sweep(1, 1'b0);

    // Start re-pulsed mid-sweep is ignored.
    clear_mask();
    sweep(0, 1'b1);

    // Start held through DONE restarts and clears results.
    for (int i = 0; i < 16; i++)
      mask[i] = golden(4'(i)) & 3'b001;
    start[0] = 1'b1;
    @(negedge clk);
    body(0, 1'b0);
    clear_mask();
    @(negedge clk);
    start[0] = 1'b0;
    chk("hold_busy", int'(busy[0]), 1);
    chk("hold_done", int'(done[0]), 0);
    body(0, 1'b0);

    // Randomized fault patterns.
    for (int r = 0; r < 6; r++) begin
      int g;
      for (int i = 0; i < 16; i++)
        mask[i] = ($urandom_range(0, 3) == 0) ?
                  3'($urandom_range(1, 7)) : 3'b000;
      g = $urandom_range(0, 2);
      sweep(g, 1'b0);
    end

    // Reset mid-sweep on a faulty comparator.
    clear_mask();
    mask[0] = 3'b111;
    mask[3] = 3'b100;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) chk_reset(g);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
